// File: rtl/pma_anchor_cache.sv
// Anchor store of {window_id, payload} entries with valid tracking, occupancy count,
// registered software reads and a sequential lowest-slot lookup engine.
//
// state | meaning
// IDLE  | waiting for lk_req; results hold their last value
// SCAN  | testing slot idx against the captured window_id, one slot per cycle
module pma_anchor_cache #(
    parameter int WID_W     = 12,
    parameter int PAYLOAD_W = 132,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    localparam int DATA_W   = WID_W + PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              inv_en,
    input  logic [ADDR_W-1:0] inv_addr,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              lk_req,
    input  logic [WID_W-1:0]  lk_wid,
    output logic              lk_busy,
    output logic              lk_done,
    output logic              lk_hit,
    output logic [ADDR_W-1:0] lk_slot,
    output logic [DATA_W-1:0] lk_data,
    output logic [ADDR_W:0]   occupancy
);

    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t              state;
    state_t              state_nx;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    valid;
    logic [WID_W-1:0]    wid_q;
    logic [ADDR_W-1:0]   idx;
    logic                wr_ok;
    logic                inv_ok;
    logic                occ_inc;
    logic [DATA_W-1:0]   scan_entry;
    logic                scan_match;
    logic                scan_last;

    // A same-slot invalidate loses to the write, so it never counts as a decrement.
    always_comb begin
        wr_ok   = wr_en && ({1'b0, wr_addr} < DEPTH_L);
        inv_ok  = inv_en && ({1'b0, inv_addr} < DEPTH_L) && valid[inv_addr]
                  && !(wr_ok && (wr_addr == inv_addr));
        occ_inc = wr_ok && !valid[wr_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !flush) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            occupancy <= '0;
        end else if (flush) begin
            valid     <= '0;
            occupancy <= '0;
        end else begin
            if (wr_ok) begin
                valid[wr_addr] <= 1'b1;
            end
            if (inv_ok) begin
                valid[inv_addr] <= 1'b0;
            end
            occupancy <= occupancy + (ADDR_W + 1)'(occ_inc) - (ADDR_W + 1)'(inv_ok);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else if ({1'b0, rd_addr} < DEPTH_L) begin
            rd_data  <= mem[rd_addr];
            rd_valid <= valid[rd_addr];
        end else begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end
    end

    // Live compare: no snapshot, so writes landing before a slot is tested are seen.
    always_comb begin
        scan_entry = mem[idx];
        scan_match = valid[idx] && (scan_entry[DATA_W-1 -: WID_W] == wid_q);
        scan_last  = (idx == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (lk_req) state_nx = SCAN;
            SCAN: if (flush || scan_match || scan_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        lk_busy = 1'b0;
        if (state == SCAN) begin
            lk_busy = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wid_q   <= '0;
            idx     <= '0;
            lk_done <= 1'b0;
            lk_hit  <= 1'b0;
            lk_slot <= '0;
            lk_data <= '0;
        end else begin
            lk_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (lk_req) begin
                        wid_q <= lk_wid;
                        idx   <= '0;
                    end
                end
                SCAN: begin
                    if (flush || (scan_last && !scan_match)) begin
                        lk_done <= 1'b1;
                        lk_hit  <= 1'b0;
                        lk_slot <= '0;
                        lk_data <= '0;
                    end else if (scan_match) begin
                        lk_done <= 1'b1;
                        lk_hit  <= 1'b1;
                        lk_slot <= idx;
                        lk_data <= scan_entry;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pma_anchor_cache.sv
// Directed bench for pma_anchor_cache: slot-array/queue-style reference model checked
// every cycle, plus hand-computed expectations from the block's documented scenarios.
module tb_pma_anchor_cache;

    localparam int WID_W     = 12;
    localparam int PAYLOAD_W = 132;
    localparam int DEPTH     = 64;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = WID_W + PAYLOAD_W;

    typedef logic [DATA_W-1:0] data_t;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              inv_en;
    logic [ADDR_W-1:0] inv_addr;
    logic              flush;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              lk_req;
    logic [WID_W-1:0]  lk_wid;
    logic              lk_busy;
    logic              lk_done;
    logic              lk_hit;
    logic [ADDR_W-1:0] lk_slot;
    logic [DATA_W-1:0] lk_data;
    logic [ADDR_W:0]   occupancy;

    pma_anchor_cache #(
        .WID_W(WID_W), .PAYLOAD_W(PAYLOAD_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .inv_en(inv_en), .inv_addr(inv_addr), .flush(flush),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .lk_req(lk_req), .lk_wid(lk_wid), .lk_busy(lk_busy), .lk_done(lk_done),
        .lk_hit(lk_hit), .lk_slot(lk_slot), .lk_data(lk_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input data_t act, input data_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain arrays for slots, a planned result and countdown for lookups.
    data_t m_mem     [DEPTH];
    bit    m_valid   [DEPTH];
    bit    m_written [DEPTH];
    data_t exp_rd_data;
    bit    exp_rd_valid;
    bit    exp_rd_known;
    bit    m_busy;
    int    m_cnt;
    bit    m_phit;
    int    m_pslot;
    bit    exp_done;
    bit    exp_hit;
    int    exp_slot;
    data_t exp_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_valid[i] = 1'b0;
            end
            exp_rd_data  = '0;
            exp_rd_valid = 1'b0;
            exp_rd_known = 1'b1;
            m_busy   = 1'b0;
            m_cnt    = 0;
            exp_done = 1'b0;
            exp_hit  = 1'b0;
            exp_slot = 0;
            exp_data = '0;
        end else begin
            exp_rd_valid = m_valid[rd_addr];
            exp_rd_known = m_written[rd_addr];
            exp_rd_data  = m_written[rd_addr] ? m_mem[rd_addr] : '0;

            exp_done = 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy = 1'b0; exp_done = 1'b1;
                    exp_hit = 1'b0; exp_slot = 0; exp_data = '0;
                end else if (m_cnt == 1) begin
                    m_busy = 1'b0; exp_done = 1'b1;
                    exp_hit  = m_phit;
                    exp_slot = m_phit ? m_pslot : 0;
                    exp_data = m_phit ? m_mem[m_pslot] : '0;
                end else begin
                    m_cnt--;
                end
            end else if (lk_req) begin
                m_phit  = 1'b0;
                m_pslot = 0;
                for (int i = 0; i < DEPTH; i++) begin
                    if (!m_phit && m_valid[i] && m_mem[i][DATA_W-1 -: WID_W] == lk_wid) begin
                        m_phit  = 1'b1;
                        m_pslot = i;
                    end
                end
                m_cnt  = m_phit ? m_pslot + 1 : DEPTH;
                m_busy = 1'b1;
            end

            if (flush) begin
                for (int i = 0; i < DEPTH; i++) begin
                    m_valid[i] = 1'b0;
                end
            end else begin
                if (inv_en && !(wr_en && wr_addr == inv_addr)) begin
                    m_valid[inv_addr] = 1'b0;
                end
                if (wr_en) begin
                    m_mem[wr_addr]     = wr_data;
                    m_valid[wr_addr]   = 1'b1;
                    m_written[wr_addr] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int n;
            n = 0;
            for (int i = 0; i < DEPTH; i++) begin
                n += int'(m_valid[i]);
            end
            chk("rd_valid", data_t'(rd_valid), data_t'(exp_rd_valid));
            if (exp_rd_known) chk("rd_data", rd_data, exp_rd_data);
            chk("occupancy", data_t'(occupancy), data_t'(n));
            chk("lk_busy", data_t'(lk_busy), data_t'(m_busy));
            chk("lk_done", data_t'(lk_done), data_t'(exp_done));
            chk("lk_hit", data_t'(lk_hit), data_t'(exp_hit));
            chk("lk_slot", data_t'(lk_slot), data_t'(exp_slot));
            chk("lk_data", lk_data, exp_data);
        end
    end

    task automatic wr(input int a, input data_t d);
        wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic inv(input int a);
        inv_en = 1'b1; inv_addr = ADDR_W'(a);
        @(negedge clk);
        inv_en = 1'b0;
    endtask

    task automatic wr_inv(input int wa, input int ia, input data_t d);
        wr_en = 1'b1; wr_addr = ADDR_W'(wa); wr_data = d;
        inv_en = 1'b1; inv_addr = ADDR_W'(ia);
        @(negedge clk);
        wr_en = 1'b0; inv_en = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
    endtask

    // Returns cycles from the acceptance edge to the cycle lk_done is seen high.
    task automatic lookup(input logic [WID_W-1:0] w, output int lat);
        lk_req = 1'b1; lk_wid = w;
        @(negedge clk);
        lk_req = 1'b0;
        lat = 0;
        while (lk_done !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic data_t ent(input logic [WID_W-1:0] w, input logic [PAYLOAD_W-1:0] p);
        return {w, p};
    endfunction

    initial begin
        int lat;
        rst = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        inv_en = 1'b0; inv_addr = '0; flush = 1'b0;
        rd_addr = '0; lk_req = 1'b0; lk_wid = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("reset rd_data", rd_data, data_t'(0));
        chk("reset rd_valid", data_t'(rd_valid), data_t'(0));
        chk("reset lk_busy", data_t'(lk_busy), data_t'(0));
        chk("reset lk_done", data_t'(lk_done), data_t'(0));
        chk("reset lk_hit", data_t'(lk_hit), data_t'(0));
        chk("reset lk_slot", data_t'(lk_slot), data_t'(0));
        chk("reset lk_data", lk_data, data_t'(0));
        chk("reset occupancy", data_t'(occupancy), data_t'(0));

        rd_addr = ADDR_W'(2);
        wr(2, ent(12'h042, 132'hDEADBEEF));
        @(negedge clk);
        chk("read slot2 wid", data_t'(rd_data[143:132]), data_t'(12'h042));
        chk("read slot2 valid", data_t'(rd_valid), data_t'(1));
        chk("occ after one write", data_t'(occupancy), data_t'(1));

        wr(5, ent(12'hABC, 132'h12345678));
        lookup(12'hABC, lat);
        chk("hit latency slot5", data_t'(lat), data_t'(6));
        chk("hit slot5 lk_hit", data_t'(lk_hit), data_t'(1));
        chk("hit slot5 lk_slot", data_t'(lk_slot), data_t'(5));
        chk("hit slot5 wid", data_t'(lk_data[143:132]), data_t'(12'hABC));

        wr(3, ent(12'h077, 132'h1));
        wr(9, ent(12'h077, 132'h2));
        lookup(12'h077, lat);
        chk("lowest match slot", data_t'(lk_slot), data_t'(3));
        chk("lowest match latency", data_t'(lat), data_t'(4));
        lookup(12'h555, lat);
        chk("miss latency", data_t'(lat), data_t'(64));
        chk("miss lk_hit", data_t'(lk_hit), data_t'(0));
        chk("miss lk_slot", data_t'(lk_slot), data_t'(0));

        do_flush();
        chk("occ after flush", data_t'(occupancy), data_t'(0));
        rd_addr = ADDR_W'(7);
        wr(7, ent(12'h007, 132'hA));
        wr(7, ent(12'h007, 132'hB));
        chk("occ rewrite slot7", data_t'(occupancy), data_t'(1));
        wr_inv(7, 7, ent(12'h007, 132'hC));
        @(negedge clk);
        chk("occ wr+inv same slot", data_t'(occupancy), data_t'(1));
        chk("valid wr+inv same slot", data_t'(rd_valid), data_t'(1));
        chk("data wr+inv same slot", rd_data, ent(12'h007, 132'hC));
        inv(7);
        chk("occ after inv slot7", data_t'(occupancy), data_t'(0));
        wr(11, ent(12'h011, 132'h11));
        wr_inv(12, 11, ent(12'h012, 132'h12));
        chk("occ wr+inv diff slots", data_t'(occupancy), data_t'(1));

        for (int i = 0; i < 4; i++) begin
            wr(i, ent(WID_W'(i + 12'h100), PAYLOAD_W'(i)));
        end
        chk("occ after fill", data_t'(occupancy), data_t'(5));
        rd_addr = ADDR_W'(10);
        wr_en = 1'b1; wr_addr = ADDR_W'(10); wr_data = ent(12'h010, 132'h10); flush = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; flush = 1'b0;
        chk("occ flush beats write", data_t'(occupancy), data_t'(0));
        @(negedge clk);
        chk("slot10 invalid after flush", data_t'(rd_valid), data_t'(0));

        wr(40, ent(12'h111, 132'h40));
        lk_req = 1'b1; lk_wid = 12'h123;
        @(negedge clk);
        lk_req = 1'b0;
        repeat (5) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("abort lk_done", data_t'(lk_done), data_t'(1));
        chk("abort lk_hit", data_t'(lk_hit), data_t'(0));
        chk("abort lk_busy", data_t'(lk_busy), data_t'(0));
        @(negedge clk);
        chk("abort done one cycle", data_t'(lk_done), data_t'(0));

        wr(30, ent(12'h2AA, 132'h30));
        lk_req = 1'b1; lk_wid = 12'h2AA;
        @(negedge clk);
        lk_req = 1'b0;
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst mid-scan lk_busy", data_t'(lk_busy), data_t'(0));
        chk("rst mid-scan lk_done", data_t'(lk_done), data_t'(0));
        chk("rst mid-scan occupancy", data_t'(occupancy), data_t'(0));
        chk("rst mid-scan valid", data_t'(dut.valid), data_t'(0));
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            chk("no done after rst", data_t'(lk_done), data_t'(0));
        end
        lookup(12'h2AA, lat);
        chk("post-rst lookup latency", data_t'(lat), data_t'(64));
        chk("post-rst lookup miss", data_t'(lk_hit), data_t'(0));

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pma_anchor_cache.md
# pma_anchor_cache

Parametrised successor to the phase memory anchor RAM: a DEPTH-entry store of {window_id, payload} anchors with per-slot valid bits, occupancy tracking, invalidate/flush, and a sequential lookup-by-window_id engine. Sits between the anchor writer and the phase-resolution logic. Software-addressed reads keep the existing one-cycle registered read behaviour. The lookup engine replaces external linear scans.

## Interface
- WID_W, 12, window_id width (top bits of each entry)
- PAYLOAD_W, 132, payload width (low bits of each entry)
- DEPTH, 64, number of slots, 2..2^ADDR_W
- ADDR_W, 6, slot address width; DATA_W = WID_W+PAYLOAD_W (derived, 144 at defaults)
- clk  in  1  single clock, all logic on posedge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write slot
- wr_data  in  DATA_W  entry, {wid[DATA_W-1 -: WID_W], payload}
- inv_en  in  1  invalidate strobe
- inv_addr  in  ADDR_W  slot to invalidate
- flush  in  1  clear all valid bits
- rd_addr  in  ADDR_W  read slot
- rd_data  out  DATA_W  registered entry at rd_addr
- rd_valid  out  1  registered valid bit of rd_addr
- lk_req  in  1  start lookup (accepted only when lk_busy=0)
- lk_wid  in  WID_W  window_id to find, captured on acceptance
- lk_busy  out  1  scan in progress
- lk_done  out  1  one-cycle result pulse
- lk_hit  out  1  match found
- lk_slot  out  ADDR_W  lowest matching slot
- lk_data  out  DATA_W  entry at lk_slot
- occupancy  out  ADDR_W+1  count of valid slots

## Operation
- Storage: data array has no reset. valid[DEPTH-1:0] flops clear on rst.
- Write: wr_en with wr_addr<DEPTH stores wr_data and sets valid. wr_addr>=DEPTH is ignored. occupancy +1 only if the slot was invalid.
- Invalidate: inv_en with a valid in-range slot clears valid and decrements occupancy. Data is untouched.
- Priority in one cycle: flush > write > invalidate.
  - flush drops a concurrent write/invalidate and sets occupancy to 0.
  - wr and inv on the same slot: write wins, valid=1.
  - wr and inv on different slots: both apply, occupancy net change applied.
- Read: read-first. rd_data/rd_valid reflect the state before any same-edge write/invalidate/flush. rd_addr>=DEPTH returns rd_valid=0, rd_data=0.
- Lookup FSM states:
  - IDLE: lk_req=1 captures lk_wid, sets idx=0, goes to SCAN, lk_busy=1.
  - SCAN: each cycle tests slot idx against live state (valid && wid==captured). No snapshot is taken, so writes during a scan are seen if they land before the slot is tested.
    - On hit: lk_hit=1, lk_slot=idx, lk_data=entry, go to IDLE, pulse lk_done.
    - If idx==DEPTH-1 with no hit: lk_hit=0, lk_slot=0, lk_data=0, go to IDLE, pulse lk_done.
    - Otherwise idx+1.
  - flush during SCAN aborts: next edge lk_done=1, lk_hit=0, go to IDLE.
- lk_hit/lk_slot/lk_data hold until the next lk_done.
- lk_req while busy is ignored, not queued.

## Timing
- Reset values: rd_data=0, rd_valid=0, lk_busy=0, lk_done=0, lk_hit=0, lk_slot=0, lk_data=0, occupancy=0, FSM=IDLE.
- rst mid-scan returns to IDLE immediately, with no lk_done pulse.
- Write visible on rd_data one edge after the write edge plus one read edge (earliest read of a slot written at edge E is sampled at E+1).
- occupancy updates at the same edge as the write/invalidate/flush.
- Lookup accepted at edge E0. Slot k is tested in the cycle after E(k). lk_done is high for the cycle after E(k+1) on a hit.
  - Miss: lk_done after E(DEPTH).
  - lk_busy drops in the same cycle lk_done rises.
- A new lk_req is accepted in the lk_done cycle.

## Test plan
- Reset, then write slot 2 {042, DEADBEEF}, read slot 2 two cycles later -> rd_data[143:132]=042, rd_valid=1, occupancy=1.
- Write slot 5 {ABC, 12345678}, lk_req wid=ABC -> lk_done 6 cycles after acceptance, lk_hit=1, lk_slot=5, lk_data[143:132]=ABC.
- Slots 3 and 9 both wid=077, lookup 077 -> lk_slot=3. Lookup 555 (absent), DEPTH=64 -> lk_done exactly 64 cycles after acceptance, lk_hit=0.
- Write slot 7 twice, then wr+inv on slot 7 in the same cycle -> occupancy stays 1, rd_valid=1. Then inv slot 7 -> occupancy 0.
- Fill 4 slots, flush concurrent with a write to slot 10 -> occupancy=0, rd_valid=0 on slot 10. Flush mid-scan -> lk_done next cycle, lk_hit=0.
- Assert rst at scan idx 20 -> lk_busy=0, no lk_done, all valid=0. A lookup after release misses.
